wr_page_packer: RTL and testbench

- Parametrised successor to the fixed 16-port write front end.
- Accepts NUM_PORTS independent write streams in sop/vld/eop framing and parses a per-packet header word.
- Packs DATA_W-bit words into PAGE_W-bit pages and round-robin arbitrates completed pages onto a single page-write interface toward the SRAM allocator.
- Provides full/almost_full backpressure per port and packet-end flushing of partial pages.

---
 rtl/wr_page_packer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_wr_page_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_page_packer.sv
// Multi-port write front end: packs sop/vld/eop word streams into pages and round-robin
// arbitrates staged pages onto one page-write interface. Optional page ECC: PACKER_ECC_EN.
module wr_page_packer #(
    parameter int NUM_PORTS      = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_PAGE = 8,
    parameter int PORT_W         = 4,
    localparam int PAGE_W        = DATA_W * WORDS_PER_PAGE,
    localparam int SRC_W         = $clog2(NUM_PORTS),
    localparam int LEN_W         = $clog2(WORDS_PER_PAGE) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        wr_sop,
    input  logic [NUM_PORTS-1:0]        wr_eop,
    input  logic [NUM_PORTS-1:0]        wr_vld,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic [NUM_PORTS-1:0]        full,
    output logic [NUM_PORTS-1:0]        almost_full,
    output logic [NUM_PORTS-1:0]        err,
    output logic                        pg_vld,
    input  logic                        pg_rdy,
    output logic [PAGE_W-1:0]           pg_data,
    output logic [7:0]                  pg_ecc,
    output logic [SRC_W-1:0]            pg_src,
    output logic [PORT_W-1:0]           pg_dest,
    output logic [2:0]                  pg_prior,
    output logic [LEN_W-1:0]            pg_len,
    output logic                        pg_first,
    output logic                        pg_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] CNT_FULL = LEN_W'(WORDS_PER_PAGE);
    localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(WORDS_PER_PAGE - 1);

    state_e               state_r    [NUM_PORTS];
    logic [LEN_W-1:0]     cnt_r      [NUM_PORTS];
    logic [PAGE_W-1:0]    asm_r      [NUM_PORTS];
    logic [PORT_W-1:0]    dest_r     [NUM_PORTS];
    logic [2:0]           prior_r    [NUM_PORTS];
    logic [NUM_PORTS-1:0] first_pend_r;
    logic [NUM_PORTS-1:0] eop_pend_r;
    logic [NUM_PORTS-1:0] err_r;

    logic [NUM_PORTS-1:0] stg_vld_r;
    logic [NUM_PORTS-1:0] stg_first_r;
    logic [NUM_PORTS-1:0] stg_last_r;
    logic [PAGE_W-1:0]    stg_data_r  [NUM_PORTS];
    logic [LEN_W-1:0]     stg_len_r   [NUM_PORTS];
    logic [PORT_W-1:0]    stg_dest_r  [NUM_PORTS];
    logic [2:0]           stg_prior_r [NUM_PORTS];
    logic [SRC_W-1:0]     rr_ptr_r;

    logic [DATA_W-1:0]    word_s  [NUM_PORTS];
    logic [LEN_W-1:0]     cnt_n_s [NUM_PORTS];
    logic [PAGE_W-1:0]    asm_n_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] full_s;
    logic [NUM_PORTS-1:0] in_data_s;
    logic [NUM_PORTS-1:0] data_acc_s;
    logic [NUM_PORTS-1:0] free_s;
    logic [NUM_PORTS-1:0] avail_s;
    logic [NUM_PORTS-1:0] remark_s;
    logic [NUM_PORTS-1:0] stage_s;
    logic                 grant_vld_s;
    logic [SRC_W-1:0]     grant_s;
    logic [SRC_W:0]       idx_s;

    // Per-port datapath: word acceptance, assembly insert, slot availability and staging decision.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            word_s[i]     = wr_data[i*DATA_W +: DATA_W];
            full_s[i]     = stg_vld_r[i] & ((cnt_r[i] == CNT_LAST) | eop_pend_r[i]);
            in_data_s[i]  = (state_r[i] == ST_DATA) & ~eop_pend_r[i] & ~wr_sop[i];
            data_acc_s[i] = in_data_s[i] & wr_vld[i] & ~full_s[i];
            cnt_n_s[i]    = cnt_r[i] + LEN_W'(data_acc_s[i]);
            for (int k = 0; k < WORDS_PER_PAGE; k++) begin
                asm_n_s[i][k*DATA_W +: DATA_W] = (data_acc_s[i] && (cnt_r[i] == LEN_W'(k)))
                                               ? word_s[i] : asm_r[i][k*DATA_W +: DATA_W];
            end
            free_s[i]   = grant_vld_s & pg_rdy & (grant_s == SRC_W'(i));
            avail_s[i]  = ~stg_vld_r[i] | free_s[i];
            // eop on a page boundary promotes this packet's still-staged page to last
            remark_s[i] = in_data_s[i] & wr_eop[i] & (cnt_n_s[i] == '0) & stg_vld_r[i]
                        & ~stg_last_r[i] & ~first_pend_r[i];
            stage_s[i]  = (in_data_s[i] & ~remark_s[i]
                           & ((wr_eop[i] & avail_s[i]) | (cnt_n_s[i] == CNT_FULL)))
                        | ((state_r[i] == ST_DATA) & eop_pend_r[i] & avail_s[i]);
        end
    end

    // Round-robin search over valid staging slots starting at the pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (SRC_W+1)'(k);
            if (idx_s >= (SRC_W+1)'(NUM_PORTS)) begin
                idx_s = idx_s - (SRC_W+1)'(NUM_PORTS);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_vld_s && stg_vld_r[idx_s[SRC_W-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_s     = idx_s[SRC_W-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    assign full        = full_s;
    assign almost_full = stg_vld_r;
    assign err         = err_r;
    assign pg_vld      = grant_vld_s;
    assign pg_src      = grant_s;
    assign pg_data     = grant_vld_s ? stg_data_r[grant_s]  : '0;
    assign pg_dest     = grant_vld_s ? stg_dest_r[grant_s]  : '0;
    assign pg_prior    = grant_vld_s ? stg_prior_r[grant_s] : 3'd0;
    assign pg_len      = grant_vld_s ? stg_len_r[grant_s]   : '0;
    assign pg_first    = grant_vld_s & stg_first_r[grant_s];
    assign pg_last     = grant_vld_s & (stg_last_r[grant_s] | remark_s[grant_s]);

    // Staging slots, per-port packet FSMs and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r     <= '0;
            first_pend_r <= '0;
            eop_pend_r   <= '0;
            err_r        <= '0;
            stg_vld_r    <= '0;
            stg_first_r  <= '0;
            stg_last_r   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_r[i]     <= ST_IDLE;
                cnt_r[i]       <= '0;
                asm_r[i]       <= '0;
                dest_r[i]      <= '0;
                prior_r[i]     <= 3'd0;
                stg_data_r[i]  <= '0;
                stg_len_r[i]   <= '0;
                stg_dest_r[i]  <= '0;
                stg_prior_r[i] <= 3'd0;
            end
        end else begin
            if (grant_vld_s && pg_rdy) begin
                rr_ptr_r <= (grant_s == SRC_W'(NUM_PORTS - 1)) ? '0 : grant_s + SRC_W'(1);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                // a completing page may reload a slot in the same cycle it drains
                if (stage_s[i]) begin
                    stg_vld_r[i]   <= 1'b1;
                    stg_data_r[i]  <= asm_n_s[i];
                    stg_len_r[i]   <= cnt_n_s[i];
                    stg_first_r[i] <= first_pend_r[i];
                    stg_last_r[i]  <= wr_eop[i] | eop_pend_r[i];
                    stg_dest_r[i]  <= dest_r[i];
                    stg_prior_r[i] <= prior_r[i];
                end else if (free_s[i]) begin
                    stg_vld_r[i] <= 1'b0;
                end else if (remark_s[i]) begin
                    stg_last_r[i] <= 1'b1;
                end

                case (state_r[i])
                    ST_IDLE: begin
                        if (wr_vld[i]) begin
                            err_r[i] <= 1'b1;
                        end
                        if (wr_sop[i]) begin
                            state_r[i]      <= ST_HDR;
                            first_pend_r[i] <= 1'b1;
                            cnt_r[i]        <= '0;
                            asm_r[i]        <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (wr_sop[i]) begin
                            err_r[i] <= 1'b1;
                        end else if (wr_eop[i]) begin
                            state_r[i] <= ST_IDLE;
                        end else if (wr_vld[i] && full_s[i]) begin
                            err_r[i] <= 1'b1;
                        end else if (wr_vld[i]) begin
                            dest_r[i]  <= word_s[i][PORT_W-1:0];
                            prior_r[i] <= word_s[i][PORT_W+2:PORT_W];
                            state_r[i] <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (eop_pend_r[i]) begin
                            if (wr_vld[i] || wr_sop[i]) begin
                                err_r[i] <= 1'b1;
                            end
                            if (avail_s[i]) begin
                                eop_pend_r[i] <= 1'b0;
                                state_r[i]    <= ST_IDLE;
                                cnt_r[i]      <= '0;
                                asm_r[i]      <= '0;
                            end
                        end else if (wr_sop[i]) begin
                            err_r[i]        <= 1'b1;
                            state_r[i]      <= ST_HDR;
                            first_pend_r[i] <= 1'b1;
                            cnt_r[i]        <= '0;
                            asm_r[i]        <= '0;
                        end else begin
                            if (wr_vld[i] && full_s[i]) begin
                                err_r[i] <= 1'b1;
                            end
                            if (remark_s[i] || (wr_eop[i] && avail_s[i])) begin
                                state_r[i] <= ST_IDLE;
                                cnt_r[i]   <= '0;
                                asm_r[i]   <= '0;
                            end else if (wr_eop[i]) begin
                                eop_pend_r[i] <= 1'b1;
                                cnt_r[i]      <= cnt_n_s[i];
                                asm_r[i]      <= asm_n_s[i];
                            end else if (stage_s[i]) begin
                                first_pend_r[i] <= 1'b0;
                                cnt_r[i]        <= '0;
                                asm_r[i]        <= '0;
                            end else begin
                                cnt_r[i] <= cnt_n_s[i];
                                asm_r[i] <= asm_n_s[i];
                            end
                        end
                    end
                    default: begin
                        state_r[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PACKER_ECC_EN
    logic [7:0] enc_ecc_s [NUM_PORTS];
    logic [7:0] stg_ecc_r [NUM_PORTS];

    if (PAGE_W != 128) begin : g_ecc_width_check
        $error("wr_page_packer: PACKER_ECC_EN requires a 128-bit page");
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ecc
        ecc_encoder u_ecc_encoder (
            .data (asm_n_s[g]),
            .ecc  (enc_ecc_s[g])
        );
    end

    // ECC code captured alongside the page when it enters the staging slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!rst_n) begin
                stg_ecc_r[i] <= 8'h00;
            end else if (stage_s[i]) begin
                stg_ecc_r[i] <= enc_ecc_s[i];
            end
        end
    end

    assign pg_ecc = grant_vld_s ? stg_ecc_r[grant_s] : 8'h00;
`else
    assign pg_ecc = 8'h00;
`endif

endmodule

// File: tb/tb_wr_page_packer.sv
// Scoreboard bench for wr_page_packer: expected pages are queued as stimulus is driven and
// compared field by field whenever the page interface handshakes.
module tb_wr_page_packer;

    localparam int NP  = 16;
    localparam int DW  = 16;
    localparam int WPP = 8;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   len;
        logic         first;
        logic         last;
        logic [3:0]   src;
        logic [3:0]   dest;
        logic [2:0]   prior;
    } page_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     wr_sop, wr_eop, wr_vld;
    logic [NP*DW-1:0]  wr_data;
    logic [NP-1:0]     full, almost_full, err;
    logic              pg_vld, pg_rdy;
    logic [127:0]      pg_data;
    logic [7:0]        pg_ecc;
    logic [3:0]        pg_src, pg_dest, pg_len;
    logic [2:0]        pg_prior;
    logic              pg_first, pg_last;

    page_t        exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] held_data;

    always #5 clk = ~clk;

    wr_page_packer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .err(err),
        .pg_vld(pg_vld), .pg_rdy(pg_rdy), .pg_data(pg_data), .pg_ecc(pg_ecc),
        .pg_src(pg_src), .pg_dest(pg_dest), .pg_prior(pg_prior), .pg_len(pg_len),
        .pg_first(pg_first), .pg_last(pg_last)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_sop = '0;
        wr_eop = '0;
        wr_vld = '0;
    endtask

    task automatic do_sop(input int p);
        wr_sop[p] = 1'b1;
        step();
    endtask

    task automatic do_eop(input int p);
        wr_eop[p] = 1'b1;
        step();
    endtask

    task automatic do_word(input int p, input logic [15:0] w);
        wr_vld[p] = 1'b1;
        wr_data[p*DW +: DW] = w;
        step();
    endtask

    task automatic expect_page(input int src, input int dest, input int prior, input int base,
                               input int n, input bit first, input bit last);
        page_t pg;
        pg = '0;
        for (int k = 0; k < n; k++) pg.data[k*DW +: DW] = 16'(base + k);
        pg.len   = 4'(n);
        pg.first = first;
        pg.last  = last;
        pg.src   = 4'(src);
        pg.dest  = 4'(dest);
        pg.prior = 3'(prior);
        exp_q.push_back(pg);
    endtask

    task automatic send_pkt(input int p, input logic [15:0] hdr, input int base, input int n);
        do_sop(p);
        do_word(p, hdr);
        for (int k = 0; k < n; k++) do_word(p, 16'(base + k));
        do_eop(p);
    endtask

    task automatic multi_pkt(input logic [NP-1:0] m, input int base);
        wr_sop = m;
        step();
        for (int p = 0; p < NP; p++) begin
            if (m[p]) begin
                wr_vld[p] = 1'b1;
                wr_data[p*DW +: DW] = 16'(((p % 8) << 4) | ((p + 1) % 16));
            end
        end
        step();
        for (int k = 0; k < WPP; k++) begin
            for (int p = 0; p < NP; p++) begin
                if (m[p]) begin
                    wr_vld[p] = 1'b1;
                    wr_data[p*DW +: DW] = 16'(base + p*16 + k);
                end
            end
            step();
        end
        wr_eop = m;
        step();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
        check_val("drain_pending", 128'(exp_q.size()), 128'd0);
    endtask

    // Scoreboard: each accepted page is compared against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pg_vld === 1'b1 && pg_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_page", 128'(exp_q.size()), 128'd1);
            end else begin
                page_t e;
                e = exp_q.pop_front();
                check_val("pg_data",  pg_data,          e.data);
                check_val("pg_len",   128'(pg_len),     128'(e.len));
                check_val("pg_first", 128'(pg_first),   128'(e.first));
                check_val("pg_last",  128'(pg_last),    128'(e.last));
                check_val("pg_src",   128'(pg_src),     128'(e.src));
                check_val("pg_dest",  128'(pg_dest),    128'(e.dest));
                check_val("pg_prior", 128'(pg_prior),   128'(e.prior));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        pg_rdy  = 1'b1;
        wr_sop  = '0;
        wr_eop  = '0;
        wr_vld  = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pg_vld",      128'(pg_vld),      128'd0);
        check_val("rst_full",        128'(full),        128'd0);
        check_val("rst_almost_full", 128'(almost_full), 128'd0);
        check_val("rst_err",         128'(err),         128'd0);
        check_val("rst_pg_data",     pg_data,           128'd0);
        rst_n = 1'b1;
        step();

        // Exact-page packet: eop finds count 0 and re-marks the staged page last
        expect_page(3, 5, 2, 16'h0001, 8, 1'b1, 1'b1);
        send_pkt(3, 16'h0025, 16'h0001, 8);
        drain(20);

        // 11 words: one full page then a 3-word flush page
        expect_page(0, 3, 1, 16'h0100, 8, 1'b1, 1'b0);
        expect_page(0, 3, 1, 16'h0108, 3, 1'b0, 1'b1);
        do_sop(0);
        do_word(0, 16'h0013);
        for (int k = 0; k < 7; k++) do_word(0, 16'(16'h0100 + k));
        do_word(0, 16'h0107);
        check_val("latency_pg_vld", 128'(pg_vld), 128'd1);
        for (int k = 8; k < 11; k++) do_word(0, 16'(16'h0100 + k));
        do_eop(0);
        drain(20);

        // Simultaneous completion on ports 1,2,7, then contention between 0 and 9
        for (int p = 0; p < NP; p++) begin
            if (p == 1 || p == 2 || p == 7) expect_page(p, (p + 1) % 16, p % 8, 16'h1000 + p*16, 8, 1'b1, 1'b1);
        end
        multi_pkt(16'h0086, 16'h1000);
        drain(20);
        expect_page(9, 10, 1, 16'h2000 + 9*16, 8, 1'b1, 1'b1);
        expect_page(0, 1, 0, 16'h2000, 8, 1'b1, 1'b1);
        multi_pkt(16'h0201, 16'h2000);
        drain(20);

        // Backpressure on port 4 with the consumer stalled
        pg_rdy = 1'b0;
        expect_page(4, 7, 4, 16'h0401, 8, 1'b1, 1'b0);
        expect_page(4, 7, 4, 16'h0409, 8, 1'b0, 1'b1);
        do_sop(4);
        do_word(4, 16'h0047);
        for (int k = 0; k < 8; k++) do_word(4, 16'(16'h0401 + k));
        check_val("af4_after_page", 128'(almost_full[4]), 128'd1);
        for (int k = 8; k < 14; k++) do_word(4, 16'(16'h0401 + k));
        check_val("full4_at_14", 128'(full[4]), 128'd0);
        do_word(4, 16'h040F);
        check_val("full4_at_15", 128'(full[4]), 128'd1);
        check_val("err4_before", 128'(err[4]), 128'd0);
        held_data = pg_data;
        do_word(4, 16'h0410);
        check_val("err4_drop", 128'(err[4]), 128'd1);
        repeat (3) step();
        check_val("stall_pg_data", pg_data, held_data);
        check_val("stall_pg_vld", 128'(pg_vld), 128'd1);
        pg_rdy = 1'b1;
        step();
        do_word(4, 16'h0410);
        do_eop(4);
        drain(20);

        // Port 6 restarts mid-packet
        expect_page(6, 6, 3, 16'h0601, 2, 1'b1, 1'b1);
        do_sop(6);
        do_word(6, 16'h0011);
        for (int k = 0; k < 3; k++) do_word(6, 16'(16'h0AA0 + k));
        do_sop(6);
        check_val("err6_resop", 128'(err[6]), 128'd1);
        check_val("err3_clean", 128'(err[3]), 128'd0);
        do_word(6, 16'h0036);
        do_word(6, 16'h0601);
        do_word(6, 16'h0602);
        do_eop(6);
        drain(20);

        // Reset mid-packet with a staged page
        pg_rdy = 1'b0;
        do_sop(5);
        do_word(5, 16'h0031);
        for (int k = 0; k < 8; k++) do_word(5, 16'(16'h0500 + k));
        do_sop(10);
        do_word(10, 16'h0044);
        for (int k = 0; k < 3; k++) do_word(10, 16'(16'h0B00 + k));
        check_val("pre_rst_pg_vld", 128'(pg_vld), 128'd1);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_pg_vld",  128'(pg_vld),      128'd0);
        check_val("mid_rst_full",    128'(full),        128'd0);
        check_val("mid_rst_af",      128'(almost_full), 128'd0);
        check_val("mid_rst_err",     128'(err),         128'd0);
        rst_n  = 1'b1;
        pg_rdy = 1'b1;
        step();
        expect_page(10, 2, 5, 16'h0A01, 4, 1'b1, 1'b1);
        send_pkt(10, 16'h0052, 16'h0A01, 4);
        drain(20);
        step();
        check_val("final_pg_vld", 128'(pg_vld), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
